// File: rtl/mmio_timer.sv
// Memory-mapped compare timer: a prescaled 32-bit up-counter with a compare match,
// optional auto-reload, a sticky pending flag and a level interrupt.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DONE = 3'd2
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          ctrl;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  pcnt;
  logic [31:0]         cmp;
  logic [31:0]         count;
  logic                pend;

  logic                en, ie, auto_rl;
  logic [2:0]          off;
  logic                wr;
  logic                wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  logic                tick, match, pcnt_clr;
  logic                addr_unused;

  assign en      = ctrl[0];
  assign ie      = ctrl[1];
  assign auto_rl = ctrl[2];

  // Word-only window; byte lanes within a word are not decoded.
  assign off         = addr[4:2];
  assign hit         = (addr[31:5] == BASE_ADDR[31:5]) && (off <= OFF_STATUS);
  assign addr_unused = ^addr[1:0];

  assign wr        = dm_w && hit;
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_presc  = wr && (off == OFF_PRESC);
  assign wr_cmp    = wr && (off == OFF_CMP);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_status = wr && (off == OFF_STATUS);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic; EN=0 always wins so software can stop the timer at any time
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en)                   state_nxt = IDLE;
        else if (match && !auto_rl) state_nxt = DONE;
      end
      DONE: begin
        if (!en)          state_nxt = IDLE;
        else if (wr_count) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: tick/match only exist while running
  always_comb begin
    tick     = 1'b0;
    match    = 1'b0;
    pcnt_clr = 1'b1;
    if (state == RUN) begin
      tick     = (pcnt == presc);
      match    = tick && (count == cmp);
      pcnt_clr = tick || (state_nxt != RUN);
    end
    if (wr_count || wr_presc) pcnt_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl  <= '0;
      presc <= '0;
      pcnt  <= '0;
      cmp   <= 32'hFFFF_FFFF;
      count <= '0;
      pend  <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl  <= wdata[2:0];
      if (wr_presc) presc <= wdata[PRESC_W-1:0];
      if (wr_cmp)   cmp   <= wdata;

      if (pcnt_clr) pcnt <= '0;
      else          pcnt <= pcnt + PRESC_W'(1);

      // A software load of COUNT overrides whatever the tick would have done.
      if (wr_count)
        count <= wdata;
      else if (match) begin
        if (auto_rl) count <= '0;
      end else if (tick)
        count <= count + 32'd1;

      // Set beats a same-cycle W1C so a match is never lost.
      if (match)
        pend <= 1'b1;
      else if (wr_status && wdata[0])
        pend <= 1'b0;
    end
  end

  assign irq = pend && ie;

  always_comb begin
    rdata = 32'h0;
    if (dm_r && hit) begin
      case (off)
        OFF_CTRL:   rdata = {29'h0, ctrl};
        OFF_PRESC:  rdata = 32'(presc);
        OFF_CMP:    rdata = cmp;
        OFF_COUNT:  rdata = count;
        OFF_STATUS: rdata = {28'h0, state, pend};
        default:    rdata = 32'h0;
      endcase
    end
  end

endmodule
